// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: bound-handling modes and default sizing.
package counter_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } mode_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // All-ones value of a given width (2..32), used as the default terminal count.
  function automatic logic [31:0] default_max(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and bound detection; no state lives here.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  MAX      = WIDTH'(default_max(WIDTH)),
  parameter bit                SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             enable,
  output logic [WIDTH-1:0] next,
  output logic             at_bound
);

  logic hit_top;
  logic hit_bottom;

  // Bounds are found by comparing against MAX/0, so q+1 never needs a carry bit.
  assign hit_top    = up  && (q == MAX);
  assign hit_bottom = !up && (q == '0);

  always_comb begin
    next     = q;
    at_bound = 1'b0;
    if (enable) begin
      at_bound = hit_top || hit_bottom;
      if (at_bound) begin
        if (SATURATE == SAT) next = q;
        else                 next = up ? '0 : MAX;
      end else begin
        next = up ? q + 1'b1 : q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down counter with parallel load, terminal-count pulse and sticky overflow flag.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  MAX      = WIDTH'(default_max(WIDTH)),
  parameter bit                SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_value;
  logic             at_bound;

  counter_next #(
    .WIDTH    (WIDTH),
    .MAX      (MAX),
    .SATURATE (SATURATE)
  ) u_next (
    .q        (q_q),
    .up       (up),
    .enable   (enable),
    .next     (step_value),
    .at_bound (at_bound)
  );

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (load) begin
      // Out-of-range load values clamp to the terminal count.
      q_d   = (d > MAX) ? MAX : d;
      ovf_d = 1'b0;
    end else if (enable) begin
      q_d   = step_value;
      tc_d  = at_bound;
      ovf_d = ovf_q | at_bound;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: wrap (4-bit, MAX=9), saturate (4-bit, MAX=9) and full-width 32-bit instances.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: WIDTH=4, MAX=9, wrap
  logic       a_reset = 1'b1, a_enable = 1'b0, a_up = 1'b0, a_load = 1'b0;
  logic [3:0] a_d = '0, a_q;
  logic       a_tc, a_ovf;
  // Instance B: WIDTH=4, MAX=9, saturate
  logic       b_reset = 1'b1, b_enable = 1'b0, b_up = 1'b0, b_load = 1'b0;
  logic [3:0] b_d = '0, b_q;
  logic       b_tc, b_ovf;
  // Instance C: WIDTH=32, MAX default, wrap
  logic        c_reset = 1'b1, c_enable = 1'b0, c_up = 1'b0, c_load = 1'b0;
  logic [31:0] c_d = '0, c_q;
  logic        c_tc, c_ovf;

  counter_updown_mod #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(a_reset), .enable(a_enable), .up(a_up), .load(a_load),
    .d(a_d), .Q(a_q), .tc(a_tc), .ovf(a_ovf)
  );

  counter_updown_mod #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(b_reset), .enable(b_enable), .up(b_up), .load(b_load),
    .d(b_d), .Q(b_q), .tc(b_tc), .ovf(b_ovf)
  );

  counter_updown_mod #(.WIDTH(32)) dut_c (
    .clk(clk), .reset(c_reset), .enable(c_enable), .up(c_up), .load(c_load),
    .d(c_d), .Q(c_q), .tc(c_tc), .ovf(c_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input int q, input bit tc, input bit ovf);
    $display("[TB] A %-10s Q=%0d tc=%0b ovf=%0b", tag, a_q, a_tc, a_ovf);
    check_eq({tag, ".Q"},   32'(a_q),   32'(q));
    check_eq({tag, ".tc"},  32'(a_tc),  32'(tc));
    check_eq({tag, ".ovf"}, 32'(a_ovf), 32'(ovf));
  endtask

  task automatic expect_b(input string tag, input int q, input bit tc, input bit ovf);
    $display("[TB] B %-10s Q=%0d tc=%0b ovf=%0b", tag, b_q, b_tc, b_ovf);
    check_eq({tag, ".Q"},   32'(b_q),   32'(q));
    check_eq({tag, ".tc"},  32'(b_tc),  32'(tc));
    check_eq({tag, ".ovf"}, 32'(b_ovf), 32'(ovf));
  endtask

  task automatic expect_c(input string tag, input logic [31:0] q, input bit tc, input bit ovf);
    $display("[TB] C %-10s Q=%08h tc=%0b ovf=%0b", tag, c_q, c_tc, c_ovf);
    check_eq({tag, ".Q"},   c_q,         q);
    check_eq({tag, ".tc"},  32'(c_tc),   32'(tc));
    check_eq({tag, ".ovf"}, 32'(c_ovf),  32'(ovf));
  endtask

  int          up_q   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  bit          up_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  bit          up_ovf [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int          dn_q   [5]  = '{2, 1, 0, 9, 8};
  bit          dn_tc  [5]  = '{0, 0, 0, 1, 0};
  bit          dn_ovf [5]  = '{0, 0, 0, 1, 1};
  int          sat_q  [4]  = '{9, 9, 9, 9};
  bit          sat_tc [4]  = '{0, 1, 1, 1};
  bit          sat_ovf[4]  = '{0, 1, 1, 1};
  logic [31:0] w_q    [3]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
  bit          w_tc   [3]  = '{0, 1, 0};
  bit          w_ovf  [3]  = '{0, 1, 1};

  initial begin
    // Reset all instances together
    a_load = 1'b1; a_enable = 1'b1; a_d = 4'd7;
    tick();
    expect_a("reset", 0, 0, 0);
    expect_b("reset", 0, 0, 0);
    expect_c("reset", 32'h0, 0, 0);
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    a_load = 1'b0;

    // A: count up 12 across the wrap
    a_enable = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      expect_a($sformatf("up%0d", i), up_q[i], up_tc[i], up_ovf[i]);
    end

    // A: load 3 then count down 5 across the wrap
    a_load = 1'b1; a_d = 4'd3; a_enable = 1'b0;
    tick();
    expect_a("load3", 3, 0, 0);
    a_load = 1'b0; a_enable = 1'b1; a_up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_a($sformatf("dn%0d", i), dn_q[i], dn_tc[i], dn_ovf[i]);
    end

    // A: out-of-range load clamps and clears ovf; load beats enable
    a_load = 1'b1; a_d = 4'd15; a_enable = 1'b0;
    tick();
    expect_a("load15", 9, 0, 0);
    a_d = 4'd4; a_enable = 1'b1; a_up = 1'b1;
    tick();
    expect_a("load_en", 4, 0, 0);
    a_load = 1'b0; a_enable = 1'b0;
    tick();
    expect_a("hold", 4, 0, 0);

    // A: build ovf=1 and Q=5, then reset overrides load and enable
    a_load = 1'b1; a_d = 4'd9;
    tick();
    a_load = 1'b0; a_enable = 1'b1; a_up = 1'b1;
    tick();
    expect_a("wrap9", 0, 1, 1);
    a_enable = 1'b0;
    tick();
    expect_a("hold_ovf", 0, 0, 1);
    a_enable = 1'b1;
    repeat (5) tick();
    expect_a("at5", 5, 0, 1);
    a_reset = 1'b1; a_load = 1'b1; a_d = 4'd7;
    tick();
    expect_a("rst_mid", 0, 0, 0);
    a_reset = 1'b0; a_load = 1'b0;
    tick();
    expect_a("resume", 1, 0, 0);
    a_enable = 1'b0;

    // B: saturate at the top, then at the bottom
    b_load = 1'b1; b_d = 4'd8;
    tick();
    expect_b("load8", 8, 0, 0);
    b_load = 1'b0; b_enable = 1'b1; b_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_b($sformatf("sat%0d", i), sat_q[i], sat_tc[i], sat_ovf[i]);
    end
    b_load = 1'b1; b_d = 4'd0;
    tick();
    expect_b("load0", 0, 0, 0);
    b_load = 1'b0; b_up = 1'b0;
    tick();
    expect_b("satlo0", 0, 1, 1);
    tick();
    expect_b("satlo1", 0, 1, 1);
    b_enable = 1'b0;
    tick();
    expect_b("sat_idle", 0, 0, 1);

    // C: 32-bit natural wrap up, then back down through zero
    c_load = 1'b1; c_d = 32'hFFFF_FFFE;
    tick();
    expect_c("loadFE", 32'hFFFF_FFFE, 0, 0);
    c_load = 1'b0; c_enable = 1'b1; c_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_c($sformatf("w%0d", i), w_q[i], w_tc[i], w_ovf[i]);
    end
    c_up = 1'b0;
    tick();
    expect_c("wdn0", 32'h0, 0, 1);
    tick();
    expect_c("wdn1", 32'hFFFF_FFFF, 1, 1);
    c_enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
